div32_seq: RTL and testbench

- Multicycle restoring divider for the datapath; the subtract-based counterpart of the 32-bit adder.
- Executes MIPS DIV/DIVU: quotient goes to LO, remainder goes to HI.
- Iterative, one quotient bit per clock, with a start/busy/done handshake to the multicycle controller.
- Constant latency regardless of operands, so the controller can stall on busy.

---
 rtl/div32_seq.sv | 188 ++++++++++++++++++
 tb/tb_div32_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div32_seq.sv
// -----------------------------------------------------------------------------
// div32_seq
//   Multicycle restoring divider for MIPS DIV/DIVU. Quotient goes to LO and
//   remainder goes to HI. One quotient bit is produced per clock, and every
//   operation takes the same number of cycles whatever the operands are, so
//   the controller only has to stall while busy is high.
//
//   Timing: start is sampled at the edge ending cycle 0. busy is high in
//   cycles 1..WIDTH+1. done pulses in cycle WIDTH+2, and busy drops in that
//   same cycle.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      request; only sampled while busy=0
//   is_signed  1 = DIV (two's complement), 0 = DIVU; captured with start
//   dividend   numerator; captured with start
//   divisor    denominator; captured with start
//   busy       operation in progress
//   done       single-cycle pulse: quotient/remainder/div_zero valid
//   quotient   result to LO (held until the next completion)
//   remainder  result to HI (held until the next completion)
//   div_zero   divisor was zero for the last completed operation
// -----------------------------------------------------------------------------
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  // Partial remainder. After every restore step it is strictly less than the
  // divisor magnitude, so its upper bit is always zero. Only WIDTH bits are
  // stored, and the extra bit exists only in the trial difference below.
  logic [WIDTH-1:0] rem_reg, rem_next;
  // Holds the dividend magnitude. It shifts out at the top while quotient
  // bits shift in at the bottom.
  logic [WIDTH-1:0] dq_reg, dq_next;
  logic [WIDTH-1:0] dvs_reg, dvs_next;
  logic [WIDTH-1:0] orig_reg, orig_next;
  logic             neg_q_reg, neg_q_next;
  logic             neg_r_reg, neg_r_next;
  logic             dz_reg, dz_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             div_zero_reg, div_zero_next;
  logic             done_reg, done_next;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];

  // Trial subtraction on WIDTH+1 bits. The MSB of diff is the borrow, and it
  // is set exactly when the shifted remainder is smaller than the divisor.
  assign shifted = {rem_reg, dq_reg[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_reg};

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    rem_next       = rem_reg;
    dq_next        = dq_reg;
    dvs_next       = dvs_reg;
    orig_next      = orig_reg;
    neg_q_next     = neg_q_reg;
    neg_r_next     = neg_r_reg;
    dz_next        = dz_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    div_zero_next  = div_zero_reg;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CALC;
          orig_next  = dividend;
          dz_next    = (divisor == '0);
          // The negation of the most negative value is the same bit pattern.
          // Read as unsigned, that pattern is already the correct magnitude.
          dq_next    = dvd_neg ? -dividend : dividend;
          dvs_next   = dvs_neg ? -divisor  : divisor;
          neg_q_next = dvd_neg ^ dvs_neg;
          neg_r_next = dvd_neg;
          rem_next   = '0;
          cnt_next   = '0;
        end
      end

      CALC: begin
        if (!diff[WIDTH]) begin
          rem_next = diff[WIDTH-1:0];
          dq_next  = {dq_reg[WIDTH-2:0], 1'b1};
        end else begin
          rem_next = shifted[WIDTH-1:0];
          dq_next  = {dq_reg[WIDTH-2:0], 1'b0};
        end
        cnt_next = cnt_reg + CNT_ONE;
        if (cnt_reg == CNT_LAST) begin
          state_next = FIX;
        end
      end

      FIX: begin
        if (dz_reg) begin
          quotient_next  = '1;
          remainder_next = orig_reg;
        end else begin
          quotient_next  = neg_q_reg ? -dq_reg  : dq_reg;
          remainder_next = neg_r_reg ? -rem_reg : rem_reg;
        end
        div_zero_next = dz_reg;
        done_next     = 1'b1;
        state_next    = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      rem_reg       <= '0;
      dq_reg        <= '0;
      dvs_reg       <= '0;
      orig_reg      <= '0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
      dz_reg        <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      div_zero_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      rem_reg       <= rem_next;
      dq_reg        <= dq_next;
      dvs_reg       <= dvs_next;
      orig_reg      <= orig_next;
      neg_q_reg     <= neg_q_next;
      neg_r_reg     <= neg_r_next;
      dz_reg        <= dz_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      div_zero_reg  <= div_zero_next;
      done_reg      <= done_next;
    end
  end

  // busy is decoded from the state. It falls in the cycle where the
  // registered done pulse appears, because FIX always returns to IDLE.
  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign quotient  = quotient_reg;
  assign remainder = remainder_reg;
  assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_div32_seq.sv
`timescale 1ns/1ps
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;
  int cyc_cnt  = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  div32_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  // Reference model: MIPS DIV/DIVU semantics.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    e.dz = 1'b0;
    if (b == 32'd0) begin
      e.q  = 32'hFFFFFFFF;
      e.r  = a;
      e.dz = 1'b1;
    end else if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        e.q = 32'h80000000;
        e.r = 32'd0;
      end else begin
        e.q = 32'($signed(a) / $signed(b));
        e.r = 32'($signed(a) % $signed(b));
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Called right after a negedge. Drives start for one edge and records the
  // cycle-0 reference.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic push, input exp_t e, output int base);
    base      = cyc_cnt;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    if (push) sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits for done, checks busy profile, latency and result against the
  // scoreboard. Optionally pulses a start at relative cycle inject_at.
  task automatic collect(input string name, input int base, input int exp_cyc,
                         input int inject_at, input logic check_after);
    int   cur;
    logic busy_ok;
    logic seen;
    exp_t e;
    busy_ok = 1'b1;
    seen    = 1'b0;
    cur     = cyc_cnt - base;
    while (!seen && cur <= exp_cyc + 20) begin
      if (inject_at != 0 && cur == inject_at) begin
        dividend = 32'd9; divisor = 32'd9; is_signed = 1'b0; start = 1'b1;
      end else if (inject_at != 0 && cur == inject_at + 1) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        @(negedge clk);
        cur = cyc_cnt - base;
      end
    end
    start = 1'b0;
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout: no done by cycle %0d, required cycle %0d", name, cur, exp_cyc);
      if (sb.size() > 0) void'(sb.pop_front());
      return;
    end
    if (cur != exp_cyc) begin
      failures++;
      $display("FAIL %s latency: done in cycle %0d, required %0d", name, cur, exp_cyc);
    end
    checks++;
    if (!busy_ok || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy: profile_ok=%b busy_at_done=%b, required 1 and 0", name, busy_ok, busy);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s scoreboard: done with no expected entry", name);
      return;
    end
    e = sb.pop_front();
    if (quotient !== e.q || remainder !== e.r || div_zero !== e.dz) begin
      failures++;
      $display("FAIL %s result: q=%h r=%h dz=%b, required q=%h r=%h dz=%b",
               name, quotient, remainder, div_zero, e.q, e.r, e.dz);
    end
    $display("[%s] cycle=%0d q=%h r=%h dz=%b", name, cur, quotient, remainder, div_zero);
    if (check_after) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL %s pulse: after done done=%b busy=%b, required 0 0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset: busy=%b done=%b q=%h r=%h dz=%b, required all zero",
               busy, done, quotient, remainder, div_zero);
    end
    $display("[reset] busy=%b done=%b q=%h r=%h dz=%b", busy, done, quotient, remainder, div_zero);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int b;
    issue(32'd100, 32'd7, 1'b0, 1'b1, exp_t'{32'd14, 32'd2, 1'b0}, b);
    collect("divu_100_7", b, 34, 0, 1'b1);
  endtask

  task automatic test_div_signed();
    int b;
    issue(32'hFFFFFFF9, 32'h2, 1'b1, 1'b1, exp_t'{32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0}, b);
    collect("div_m7_2", b, 34, 0, 1'b1);
    issue(32'h7, 32'hFFFFFFFE, 1'b1, 1'b1, exp_t'{32'hFFFFFFFD, 32'h1, 1'b0}, b);
    collect("div_7_m2", b, 34, 0, 1'b1);
  endtask

  task automatic test_boundary();
    int b;
    issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, exp_t'{32'h80000000, 32'h0, 1'b0}, b);
    collect("div_overflow", b, 34, 0, 1'b1);
    issue(32'hFFFFFFFF, 32'h10, 1'b0, 1'b1, exp_t'{32'h0FFFFFFF, 32'hF, 1'b0}, b);
    collect("divu_max_16", b, 34, 0, 1'b1);
    issue(32'h0, 32'h5, 1'b1, 1'b1, exp_t'{32'h0, 32'h0, 1'b0}, b);
    collect("div_zero_dividend", b, 34, 0, 1'b1);
  endtask

  task automatic test_div_zero();
    int b;
    issue(32'd5, 32'd0, 1'b0, 1'b1, exp_t'{32'hFFFFFFFF, 32'h5, 1'b1}, b);
    collect("divu_5_0", b, 34, 0, 1'b1);
    issue(32'hFFFFFFFB, 32'd0, 1'b1, 1'b1, exp_t'{32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1}, b);
    collect("div_m5_0", b, 34, 0, 1'b1);
  endtask

  task automatic test_start_ignored();
    int b;
    int extra;
    issue(32'd20, 32'd3, 1'b0, 1'b1, exp_t'{32'd6, 32'd2, 1'b0}, b);
    collect("ignored_start", b, 34, 5, 1'b1);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignored_start extra: %0d cycles with done/busy after completion, required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int b1;
    int b2;
    issue(32'd20, 32'd3, 1'b0, 1'b1, exp_t'{32'd6, 32'd2, 1'b0}, b1);
    collect("b2b_first", b1, 34, 0, 1'b0);
    // Still in the done cycle: this start must be accepted.
    issue(32'd9, 32'd9, 1'b0, 1'b1, exp_t'{32'd1, 32'd0, 1'b0}, b2);
    collect("b2b_second", b1, 68, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int b;
    int pulses;
    // Leave non-zero results behind so the reset clearing is visible.
    issue(32'd50, 32'd7, 1'b0, 1'b1, exp_t'{32'd7, 32'd1, 1'b0}, b);
    collect("pre_reset", b, 34, 0, 1'b1);
    issue(32'd1000, 32'd3, 1'b0, 1'b0, exp_t'{32'd0, 32'd0, 1'b0}, b);
    while (cyc_cnt - b < 10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || quotient !== 32'd0 || remainder !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b q=%h r=%h, required 0 0 0 0", busy, done, quotient, remainder);
    end
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      failures++;
      $display("FAIL reset_mid done: %0d done pulses after abandon, required 0", pulses);
    end
    $display("[reset_mid] busy=%b q=%h r=%h pulses=%0d", busy, quotient, remainder, pulses);
    issue(32'd1000, 32'd3, 1'b0, 1'b1, exp_t'{32'd333, 32'd1, 1'b0}, b);
    collect("after_reset", b, 34, 0, 1'b1);
  endtask

  task automatic test_random();
    int b;
    logic [31:0] a;
    logic [31:0] d;
    logic s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      d = (i % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 3 == 0) d = -d;
      s = 1'($urandom_range(0, 1));
      issue(a, d, s, 1'b1, model(a, d, s), b);
      collect($sformatf("random_%0d", i), b, 34, 0, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_div_signed();
    test_boundary();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
